fir_sequencer: RTL and testbench

- Moore control FSM for the FIR filter datapath: a shared 16-register file plus a single ALU.
- Issues one datapath operation per cycle: op/src1/src2/dest.
- Runs the coefficient-load sequence on lc and the sample shift/multiply-accumulate sequence on dr.
- Drives the sample counter and the busy/error status; the 16-bit output magnitude stage downstream reads R0.

---
 rtl/fir_sequencer_if.sv | 25 ++
 rtl/fir_sequencer.sv | 128 ++++++++++++
 tb/tb_fir_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sequencer_if.sv
// Host/datapath handshake bundle for the FIR control sequencer.
// The sequencer side takes the master modport; the host/datapath side takes the slave modport.
interface fir_sequencer_if;
   logic       dr;
   logic       lc;
   logic       overflow;
   logic [2:0] op;
   logic [3:0] src1;
   logic [3:0] src2;
   logic [3:0] dest;
   logic       modwait;
   logic       cnt_up;
   logic       clear;
   logic       err;

   modport master (
      input  dr, lc, overflow,
      output op, src1, src2, dest, modwait, cnt_up, clear, err
   );

   modport slave (
      output dr, lc, overflow,
      input  op, src1, src2, dest, modwait, cnt_up, clear, err
   );
endinterface

// File: rtl/fir_sequencer.sv
// Moore control FSM for the FIR datapath: coefficient load on lc, sample shift/MAC on dr.
// Issues one register-file/ALU operation per cycle; a 3-bit tap index walks the taps.
module fir_sequencer #(
   parameter int NTAPS = 4
) (
   input logic           clk,
   input logic           rst,
   fir_sequencer_if.master bus
);
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_COPY  = 3'd1;
   localparam logic [2:0] OP_LOAD1 = 3'd2;
   localparam logic [2:0] OP_LOAD2 = 3'd3;
   localparam logic [2:0] OP_ADD   = 3'd4;
   localparam logic [2:0] OP_SUB   = 3'd5;
   localparam logic [2:0] OP_MUL   = 3'd6;

   localparam logic [2:0] NT  = 3'(NTAPS);
   localparam logic [3:0] NT4 = 4'(NTAPS);

   typedef enum logic [3:0] {
      S_IDLE, S_STORE, S_ZERO, S_SHIFT, S_MUL, S_ADD, S_CLOAD, S_WAITC, S_EIDLE
   } state_t;

   state_t     state, state_n;
   logic [2:0] idx, idx_n;
   logic [3:0] idx4;

   assign idx4 = {1'b0, idx};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= 3'd0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
      end
   end

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      bus.op      = OP_NOP;
      bus.src1    = 4'd0;
      bus.src2    = 4'd0;
      bus.dest    = 4'd0;
      bus.modwait = 1'b0;
      bus.cnt_up  = 1'b0;
      bus.clear   = 1'b0;
      bus.err     = 1'b0;
      unique case (state)
         S_IDLE, S_EIDLE: begin
            bus.err = (state == S_EIDLE);
            if (bus.dr) begin
               state_n = S_STORE;
            end else if (bus.lc) begin
               state_n = S_CLOAD;
               idx_n   = 3'd1;
            end
         end
         S_STORE: begin
            bus.op      = OP_LOAD1;
            bus.dest    = 4'd15;
            bus.modwait = 1'b1;
            // a sample is only accepted if dr is still high one cycle later
            state_n     = bus.dr ? S_ZERO : S_EIDLE;
         end
         S_ZERO: begin
            bus.op      = OP_SUB;
            bus.modwait = 1'b1;
            bus.cnt_up  = 1'b1;
            state_n     = S_SHIFT;
            idx_n       = NT;
         end
         S_SHIFT: begin
            bus.op      = OP_COPY;
            bus.dest    = idx4;
            bus.modwait = 1'b1;
            if (idx == 3'd1) begin
               bus.src1 = 4'd15;
               state_n  = S_MUL;
               idx_n    = 3'd1;
            end else begin
               bus.src1 = idx4 - 4'd1;
               idx_n    = idx - 3'd1;
            end
         end
         S_MUL: begin
            bus.op      = OP_MUL;
            bus.src1    = idx4;
            bus.src2    = NT4 + idx4;
            bus.dest    = 4'd13;
            bus.modwait = 1'b1;
            state_n     = S_ADD;
         end
         S_ADD: begin
            bus.op      = OP_ADD;
            bus.src2    = 4'd13;
            bus.modwait = 1'b1;
            if (bus.overflow) begin
               state_n = S_EIDLE;
            end else if (idx < NT) begin
               state_n = S_MUL;
               idx_n   = idx + 3'd1;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_CLOAD: begin
            bus.op      = OP_LOAD2;
            bus.dest    = NT4 + idx4;
            bus.modwait = 1'b1;
            bus.clear   = (idx == 3'd1);
            if (idx < NT) begin
               state_n = S_WAITC;
               idx_n   = idx + 3'd1;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_WAITC: begin
            if (bus.lc) state_n = S_CLOAD;
         end
         default: state_n = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_fir_sequencer.sv
// Randomized bench for fir_sequencer: expected per-cycle outputs come from a trace model
// built directly from the operation sequences, with don't-care inputs randomized.
module tb_fir_sequencer;
   localparam int N = 4;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] s1, s2, d;
      logic       mw, cu, cl, er;
   } out_t;

   typedef struct packed {
      logic dr, lc, ov;
      out_t e;
   } step_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   step_t steps[$];

   fir_sequencer_if bus();

   fir_sequencer #(.NTAPS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic out_t o(int op, int s1, int s2, int d, bit mw, bit cu, bit cl, bit er);
      out_t r;
      r.op = 3'(op); r.s1 = 4'(s1); r.s2 = 4'(s2); r.d = 4'(d);
      r.mw = mw; r.cu = cu; r.cl = cl; r.er = er;
      return r;
   endfunction

   function automatic out_t cur();
      out_t r;
      r.op = bus.op; r.s1 = bus.src1; r.s2 = bus.src2; r.d = bus.dest;
      r.mw = bus.modwait; r.cu = bus.cnt_up; r.cl = bus.clear; r.er = bus.err;
      return r;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(logic dr, logic lc, logic ov, out_t e);
      step_t s;
      s.dr = dr; s.lc = lc; s.ov = ov; s.e = e;
      steps.push_back(s);
   endtask

   task automatic idle_steps(int n, bit er);
      for (int k = 0; k < n; k++) push(1'b0, 1'b0, rb(), o(0, 0, 0, 0, 0, 0, 0, er));
   endtask

   // Sample sequence from IDLE/EIDLE. ovk>0: overflow in ADD(ovk). stopk>0: stop after MUL(stopk).
   task automatic add_sample_seq(bit first_lc, int ovk, int stopk);
      push(1'b1, first_lc, rb(), o(2, 0, 0, 15, 1, 0, 0, 0));
      push(1'b1, rb(), rb(), o(5, 0, 0, 0, 1, 1, 0, 0));
      for (int i = N; i >= 2; i--) push(rb(), rb(), rb(), o(1, i - 1, 0, i, 1, 0, 0, 0));
      push(rb(), rb(), rb(), o(1, 15, 0, 1, 1, 0, 0, 0));
      for (int i = 1; i <= N; i++) begin
         push(rb(), rb(), (i == 1) ? rb() : 1'b0, o(6, i, N + i, 13, 1, 0, 0, 0));
         if (stopk == i) return;
         push(rb(), rb(), rb(), o(4, 0, 13, 0, 1, 0, 0, 0));
         if (ovk == i) begin
            push(rb(), rb(), 1'b1, o(0, 0, 0, 0, 0, 0, 0, 1));
            return;
         end
      end
      push(rb(), rb(), 1'b0, o(0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic add_coef_load();
      int g;
      for (int j = 1; j <= N; j++) begin
         push((j == 1) ? 1'b0 : rb(), 1'b1, rb(), o(3, 0, 0, N + j, 1, 0, j == 1, 0));
         if (j < N) begin
            g = $urandom_range(1, 3);
            push(rb(), rb(), rb(), o(0, 0, 0, 0, 0, 0, 0, 0));
            for (int k = 1; k < g; k++) push(rb(), 1'b0, rb(), o(0, 0, 0, 0, 0, 0, 0, 0));
         end else begin
            push(rb(), rb(), rb(), o(0, 0, 0, 0, 0, 0, 0, 0));
         end
      end
   endtask

   task automatic test_reset();
      step_t s;
      repeat (2) @(negedge clk);
      checks++;
      if (cur() !== o(0, 0, 0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL reset_init got %h want %h", cur(), o(0, 0, 0, 0, 0, 0, 0, 0));
      end
      rst = 1'b0;
      add_sample_seq(0, 0, 2);
      while (steps.size() > 0) begin
         s = steps.pop_front();
         bus.dr = s.dr; bus.lc = s.lc; bus.overflow = s.ov;
         @(negedge clk);
         checks++;
         if (cur() !== s.e) begin errors++; $display("FAIL reset_pre got %h want %h", cur(), s.e); end
      end
      rst = 1'b1; bus.dr = 1'b1; bus.lc = 1'b1; bus.overflow = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (cur() !== o(0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_mid got %h want %h", cur(), o(0, 0, 0, 0, 0, 0, 0, 0));
         end
      end
      rst = 1'b0; bus.dr = 1'b0; bus.lc = 1'b0; bus.overflow = 1'b0;
      @(negedge clk);
      checks++;
      if (cur() !== o(0, 0, 0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL reset_idle got %h want %h", cur(), o(0, 0, 0, 0, 0, 0, 0, 0));
      end
      add_sample_seq(0, 0, 0);
      while (steps.size() > 0) begin
         s = steps.pop_front();
         bus.dr = s.dr; bus.lc = s.lc; bus.overflow = s.ov;
         @(negedge clk);
         checks++;
         if (cur() !== s.e) begin errors++; $display("FAIL reset_post got %h want %h", cur(), s.e); end
      end
   endtask

   task automatic test_coef_load();
      step_t s;
      idle_steps(1, 0);
      add_coef_load();
      while (steps.size() > 0) begin
         s = steps.pop_front();
         bus.dr = s.dr; bus.lc = s.lc; bus.overflow = s.ov;
         @(negedge clk);
         checks++;
         if (cur() !== s.e) begin errors++; $display("FAIL coef_load got %h want %h", cur(), s.e); end
      end
   endtask

   task automatic test_sample();
      step_t s;
      repeat (3) begin
         idle_steps($urandom_range(1, 3), 0);
         add_sample_seq(0, 0, 0);
      end
      while (steps.size() > 0) begin
         s = steps.pop_front();
         bus.dr = s.dr; bus.lc = s.lc; bus.overflow = s.ov;
         @(negedge clk);
         checks++;
         if (cur() !== s.e) begin errors++; $display("FAIL sample got %h want %h", cur(), s.e); end
      end
   endtask

   task automatic test_dropped_dr();
      step_t s;
      idle_steps(1, 0);
      push(1'b1, 1'b0, rb(), o(2, 0, 0, 15, 1, 0, 0, 0));
      push(1'b0, rb(), rb(), o(0, 0, 0, 0, 0, 0, 0, 1));
      idle_steps(2, 1);
      add_sample_seq(0, 0, 0);
      while (steps.size() > 0) begin
         s = steps.pop_front();
         bus.dr = s.dr; bus.lc = s.lc; bus.overflow = s.ov;
         @(negedge clk);
         checks++;
         if (cur() !== s.e) begin errors++; $display("FAIL dropped_dr got %h want %h", cur(), s.e); end
      end
   endtask

   task automatic test_overflow();
      step_t s;
      idle_steps(1, 0);
      add_sample_seq(0, 2, 0);
      idle_steps(1, 1);
      add_sample_seq(0, $urandom_range(1, N), 0);
      add_coef_load();
      while (steps.size() > 0) begin
         s = steps.pop_front();
         bus.dr = s.dr; bus.lc = s.lc; bus.overflow = s.ov;
         @(negedge clk);
         checks++;
         if (cur() !== s.e) begin errors++; $display("FAIL overflow got %h want %h", cur(), s.e); end
      end
   endtask

   task automatic test_back_to_back();
      step_t s;
      idle_steps(1, 0);
      add_sample_seq(1, 0, 0);
      add_sample_seq(1, 0, 0);
      add_coef_load();
      add_sample_seq(0, 0, 0);
      while (steps.size() > 0) begin
         s = steps.pop_front();
         bus.dr = s.dr; bus.lc = s.lc; bus.overflow = s.ov;
         @(negedge clk);
         checks++;
         if (cur() !== s.e) begin errors++; $display("FAIL back_to_back got %h want %h", cur(), s.e); end
      end
   endtask

   initial begin
      bus.dr = 1'b0; bus.lc = 1'b0; bus.overflow = 1'b0;
      test_reset();
      test_coef_load();
      test_sample();
      test_dropped_dr();
      test_overflow();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
